// File: rtl/tdc_multi_counter.sv
// tdc_multi_counter
//   Multi-channel time-to-digital counter. Each channel counts prescaled clock
//   ticks between its own start and stop requests. While it counts, it holds
//   its ring-oscillator enable high. Finished measurements wait in their
//   channel (DONE state) until a round-robin arbiter moves them into a single
//   valid/ready output register.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   prescale   terminal count P; one tick every P+1 cycles (latched at start)
//   start      per-channel start request (level)
//   stop       per-channel stop request (level)
//   ro_en      per-channel ring-oscillator enable (channel is counting)
//   busy       per-channel not-idle flag (counting or holding a result)
//   res_valid  result register holds a result
//   res_ready  consumer accepts the presented result
//   res_ch     channel index of the presented result
//   res_count  measured tick count, saturating
//   res_ovf    count saturated during the measurement
module tdc_multi_counter #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [PRESC_W-1:0]                           prescale,
    input  logic [NUM_CH-1:0]                            start,
    input  logic [NUM_CH-1:0]                            stop,
    output logic [NUM_CH-1:0]                            ro_en,
    output logic [NUM_CH-1:0]                            busy,
    output logic                                         res_valid,
    input  logic                                         res_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] res_ch,
    output logic [CNT_W-1:0]                             res_count,
    output logic                                         res_ovf
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } ch_state_t;

    ch_state_t          state [NUM_CH];
    logic [PRESC_W-1:0] presc [NUM_CH];
    logic [PRESC_W-1:0] p_lat [NUM_CH];
    logic [CNT_W-1:0]   cnt   [NUM_CH];
    logic [NUM_CH-1:0]  ovf;

    logic [NUM_CH-1:0]  done;
    logic [NUM_CH-1:0]  grant;
    logic [CH_W-1:0]    ptr;
    logic               found;
    int                 arb_idx;
    int                 win_idx;
    logic               load_en;
    logic [CNT_W-1:0]   sel_cnt;
    logic               sel_ovf;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Outputs decoded straight from registered channel state.
    always_comb begin
        ro_en = '0;
        busy  = '0;
        done  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ro_en[i] = (state[i] == S_COUNT);
            busy[i]  = (state[i] != S_IDLE);
            done[i]  = (state[i] == S_DONE);
        end
    end

    // Circular search for the first DONE channel at or after the pointer.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        win_idx = 0;
        arb_idx = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            arb_idx = (int'(ptr) + k) % NUM_CH;
            if (!found && done[arb_idx]) begin
                found   = 1'b1;
                win_idx = arb_idx;
            end
        end
        grant[win_idx] = found;
    end

    assign load_en = found && (!res_valid || res_ready);

    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                sel_cnt = cnt[i];
                sel_ovf = ovf[i];
            end
        end
    end

    // Per-channel measurement state machines.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= S_IDLE;
                presc[i] <= '0;
                p_lat[i] <= '0;
                cnt[i]   <= '0;
                ovf[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (state[i])
                    S_IDLE: begin
                        // Start wins over a simultaneous stop.
                        if (start[i]) begin
                            state[i] <= S_COUNT;
                            presc[i] <= '0;
                            p_lat[i] <= prescale;
                            cnt[i]   <= '0;
                            ovf[i]   <= 1'b0;
                        end
                    end
                    S_COUNT: begin
                        // The stop edge still applies its own tick when due.
                        if (presc[i] == p_lat[i]) begin
                            presc[i] <= '0;
                            cnt[i]   <= sat_inc(cnt[i]);
                            if (&cnt[i]) begin
                                ovf[i] <= 1'b1;
                            end
                        end else begin
                            presc[i] <= presc[i] + PRESC_W'(1);
                        end
                        if (stop[i]) begin
                            state[i] <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (load_en && grant[i]) begin
                            state[i] <= S_IDLE;
                        end
                    end
                    default: state[i] <= S_IDLE;
                endcase
            end
        end
    end

    // Shared result register with round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_count <= '0;
            res_ovf   <= 1'b0;
            ptr       <= '0;
        end else if (load_en) begin
            res_valid <= 1'b1;
            res_ch    <= CH_W'(win_idx);
            res_count <= sel_cnt;
            res_ovf   <= sel_ovf;
            ptr       <= CH_W'((win_idx + 1) % NUM_CH);
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: doc/tdc_multi_counter.md
# tdc_multi_counter

Multi-channel, parametrised time-to-digital counter. Each of `NUM_CH` channels measures the interval between its own start and stop pulses as a count of prescaled clock ticks, and enables its ring oscillator while measuring. Completed measurements are queued per channel and drained through one shared valid/ready result port, using round-robin arbitration. It sits between the ring-oscillator tiles and the readout/register interface, in place of the single-channel delay counter.

## Interface
Parameters:
- `NUM_CH`, default 4: number of independent channels, at least 1.
- `CNT_W`, default 32: width of the result counter.
- `PRESC_W`, default 8: width of the prescaler terminal-count input.

Ports:
- `clk`, in, 1: system clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset. Synchronous, active-low.
- `prescale`, in, `PRESC_W`: prescaler terminal count P. A tick occurs every P+1 cycles.
- `start`, in, `NUM_CH`: per-channel start request, level sampled.
- `stop`, in, `NUM_CH`: per-channel stop request, level sampled.
- `ro_en`, out, `NUM_CH`: per-channel ring-oscillator enable. High exactly while the channel is in COUNT.
- `busy`, out, `NUM_CH`: channel is not IDLE, i.e. in COUNT or DONE.
- `res_valid`, out, 1: a result is presented.
- `res_ready`, in, 1: consumer accepts the result.
- `res_ch`, out, `$clog2(NUM_CH)` (minimum 1): channel index of the presented result.
- `res_count`, out, `CNT_W`: measured tick count.
- `res_ovf`, out, 1: the count saturated during the measurement.

## Operation
- Each channel has a state machine with states IDLE, COUNT and DONE, plus its own prescaler, latched P, count and ovf flag.
- **IDLE to COUNT:** happens when `start[i]`=1. On this edge:
  - prescaler is cleared to 0;
  - count is cleared to 0;
  - ovf is cleared to 0;
  - `prescale` is latched; later changes to `prescale` do not affect this measurement.
- **Start and stop together in IDLE:** start wins and the channel enters COUNT. Stop is ignored.
- **In COUNT, on every edge:**
  - If prescaler equals latched P, the prescaler wraps to 0 and a tick occurs. Otherwise the prescaler increments.
  - On a tick, count increments. If count is already at all-ones it stays there and ovf is set. The count never wraps.
- **COUNT to DONE:** happens when `stop[i]`=1. The stop edge still applies its own tick if one is due. `start[i]` is ignored while in COUNT.
- **In DONE:** count and ovf are frozen. `start[i]` and `stop[i]` are ignored, and no new measurement can begin until the result has been loaded.
- **DONE to IDLE:** happens on the edge where the channel's result is loaded into the output register.
- **Output register:** holds `res_valid`, `res_ch`, `res_count` and `res_ovf`.
  - It loads when (`res_valid`=0 or `res_ready`=1) and at least one channel is in DONE.
  - The winner is the lowest-index DONE channel at or after the pointer, searching circularly.
  - After a load, the pointer moves to winner+1, modulo `NUM_CH`.
  - If `res_ready`=1 and no channel is in DONE, `res_valid` drops to 0.
  - While `res_valid`=1 and `res_ready`=0, all `res_*` outputs are held stable.
- **Reset (`rst_n`=0 at an edge):**
  - all channels go to IDLE;
  - all prescalers, counts and ovf flags clear to 0;
  - the round-robin pointer is set to 0;
  - `res_valid`, `res_ch`, `res_count` and `res_ovf` are 0;
  - `ro_en`=0 and `busy`=0.
- **Reset mid-operation:** in-flight measurements and pending results are discarded with no partial output.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from `start`/`stop` to any output.
- If `start[i]` is sampled at edge E0, then `ro_en[i]`=1 and `busy[i]`=1 from after E0.
- The first tick happens at edge E0+P+1, then every P+1 edges after that.
- **Stop:** if `stop[i]` is sampled at edge Es, then `ro_en[i]`=0 after Es.
  - Result value = floor((Es−E0)/(P+1)), saturated at 2^`CNT_W`−1.
  - Earliest `res_valid`=1 is after edge Es+1.
  - `busy[i]`=0 after Es+1, if the channel wins arbitration at Es+1.
- **Back-to-back results:** with `res_ready` held at 1, one result is loaded per cycle.
- **Restarting a channel:** `start[i]` is accepted no earlier than the edge after its result is loaded, so the minimum channel restart interval is 2 cycles after stop.
- **Fairness:** with all channels in DONE and `res_ready`=1, results emerge in channel order starting at the pointer. No channel waits more than `NUM_CH` load slots.

## Test plan
- **Basic measurement:** `NUM_CH`=4, P=0. Start ch0 at edge 0, stop at edge 10 → one result with `res_ch`=0, `res_count`=10, `res_ovf`=0. `ro_en[0]` is high for cycles 1–10.
- **Prescale latching:** P=3. Start ch1 at edge 0, change `prescale` to 0 at edge 2, stop at edge 9 → `res_count`=2.
- **Saturation:** `CNT_W`=4, P=0. Start at edge 0, stop at edge 20 → `res_count`=15, `res_ovf`=1.
- **Arbitration and backpressure:**
  - Stop all 4 channels on the same edge with `res_ready`=0 for 5 cycles → `res_valid` is held with `res_ch`=0 and stable data.
  - Then raise `res_ready` → channels 1, 2, 3 follow on consecutive cycles, then `res_valid`=0.
- **Simultaneous and ignored events:**
  - Start and stop together in IDLE → enters COUNT.
  - Start during COUNT → count not cleared.
  - Start during DONE → ignored; the next start after the load is accepted.
- **Reset mid-operation:** drive `rst_n`=0 for 1 cycle with ch2 in COUNT and ch3 in DONE presenting a result → after that edge, all outputs are 0 and no stale result appears afterwards.
